// File: rtl/gf_table_builder_if.sv
// Control and lookup bundle for gf_table_builder.
// start is a one-cycle pulse with no backpressure: the builder captures m/prim_poly on it and ignores it while busy.
interface gf_table_builder_if;
  logic       start;
  logic [2:0] m;
  logic [4:0] prim_poly;
  logic       busy;
  logic       ready;
  logic       err;
  logic [3:0] lk_exp_in;
  logic [3:0] lk_vec_out;
  logic [3:0] lk_vec_in;
  logic [3:0] lk_exp_out;

  modport master (
    output start, m, prim_poly, lk_exp_in, lk_vec_in,
    input  busy, ready, err, lk_vec_out, lk_exp_out
  );

  modport slave (
    input  start, m, prim_poly, lk_exp_in, lk_vec_in,
    output busy, ready, err, lk_vec_out, lk_exp_out
  );
endinterface

// File: rtl/gf_table_builder.sv
// Builds exponent->vector and vector->exponent tables for GF(2^3)/GF(2^4) by stepping an LFSR,
// then serves both lookups with one registered cycle of latency.
module gf_table_builder (
  input  logic              clk,
  input  logic              rst_n,
  gf_table_builder_if.slave bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_BUILD, S_READY, S_ERR} state_t;

  state_t     state_q, state_d;
  logic       m4_q, m4_d;
  logic [3:0] poly_q, poly_d;
  logic [3:0] s_q, s_d;
  logic [3:0] k_q, k_d;
  logic [3:0] exp_tab [16];
  logic [3:0] log_tab [16];
  logic       tab_we;
  logic [3:0] tab_k, tab_vec;
  logic       legal;
  logic [3:0] s_shift, s_next, rev_s, k_last;
  logic       s_msb;
  logic       rdy, exp_ok, vec_ok;

  // Element encoding puts x^0 in the top bit of the M-bit field.
  assign rev_s   = m4_q ? {s_q[0], s_q[1], s_q[2], s_q[3]} : {1'b0, s_q[0], s_q[1], s_q[2]};
  assign s_shift = m4_q ? {s_q[2:0], 1'b0} : {1'b0, s_q[1:0], 1'b0};
  assign s_msb   = m4_q ? s_q[3] : s_q[2];
  assign s_next  = s_shift ^ (s_msb ? poly_q : 4'd0);
  assign k_last  = m4_q ? 4'd15 : 4'd7;

  assign legal = ((bus.m == 3'd3) && bus.prim_poly[3] && bus.prim_poly[0] && !bus.prim_poly[4]) ||
                 ((bus.m == 3'd4) && bus.prim_poly[4] && bus.prim_poly[0]);

  always_comb begin
    state_d = state_q;
    m4_d    = m4_q;
    poly_d  = poly_q;
    s_d     = s_q;
    k_d     = k_q;
    tab_we  = 1'b0;
    tab_k   = k_q;
    tab_vec = rev_s;
    case (state_q)
      S_BUILD: begin
        tab_we = 1'b1;
        k_d    = k_q + 4'd1;
        s_d    = s_next;
        // Returning to 1 before the last code means the period is short: not primitive.
        if (k_q == k_last)        state_d = (s_next == 4'd1) ? S_READY : S_ERR;
        else if (s_next == 4'd1)  state_d = S_ERR;
      end
      default: begin
        if (bus.start) begin
          m4_d   = (bus.m == 3'd4);
          poly_d = (bus.m == 3'd4) ? bus.prim_poly[3:0] : {1'b0, bus.prim_poly[2:0]};
          if (legal) begin
            state_d = S_BUILD;
            s_d     = 4'd1;
            k_d     = 4'd1;
            tab_we  = 1'b1;
            tab_k   = 4'd0;
            tab_vec = 4'd0;
          end else begin
            state_d = S_ERR;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      m4_q    <= 1'b0;
      poly_q  <= 4'd0;
      s_q     <= 4'd0;
      k_q     <= 4'd0;
    end else begin
      state_q <= state_d;
      m4_q    <= m4_d;
      poly_q  <= poly_d;
      s_q     <= s_d;
      k_q     <= k_d;
    end
  end

  // Table storage carries no reset; contents are only observable once READY.
  always_ff @(posedge clk) begin
    if (rst_n && tab_we) begin
      exp_tab[tab_k]   <= tab_vec;
      log_tab[tab_vec] <= tab_k;
    end
  end

  assign rdy    = (state_q == S_READY);
  assign exp_ok = rdy && (m4_q || !bus.lk_exp_in[3]);
  assign vec_ok = rdy && (m4_q || !bus.lk_vec_in[3]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.lk_vec_out <= 4'd0;
      bus.lk_exp_out <= 4'd0;
    end else begin
      bus.lk_vec_out <= exp_ok ? exp_tab[bus.lk_exp_in] : 4'd0;
      bus.lk_exp_out <= vec_ok ? log_tab[bus.lk_vec_in] : 4'd0;
    end
  end

  assign bus.busy  = (state_q == S_BUILD);
  assign bus.ready = rdy;
  assign bus.err   = (state_q == S_ERR);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_gf_table_builder.sv
// Bench for gf_table_builder: build sequences with timing checks, and lookups checked
// through an expected-value queue fed from constants and a GF reference model.
module tb_gf_table_builder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  gf_table_builder_if bus ();

  gf_table_builder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  logic [3:0] mdl_exp [16];
  logic [3:0] mdl_log [16];
  logic       mdl_ready = 1'b0;
  logic       mdl_m4 = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask

  // Reference: multiply by x in standard order, reduce by the full polynomial.
  // Returns the multiplicative period of x, or 0 when m/poly are illegal.
  function automatic int build_model(input int mm, input logic [4:0] p);
    int         e;
    logic [3:0] v;
    int         nmax;
    if (!((mm == 3 && p[3] && p[0] && !p[4]) || (mm == 4 && p[4] && p[0]))) return 0;
    nmax = (1 << mm) - 1;
    mdl_exp[0] = 4'd0;
    mdl_log[0] = 4'd0;
    e = 1;
    for (int k = 1; k <= nmax; k++) begin
      v = 4'd0;
      for (int i = 0; i < mm; i++) v[mm-1-i] = e[i];
      mdl_exp[k] = v;
      mdl_log[v] = 4'(k);
      e = e << 1;
      if ((e & (1 << mm)) != 0) e = e ^ int'(p);
      if (e == 1) return k;
    end
    return nmax + 1;
  endfunction

  task automatic run_build(input int mm, input logic [4:0] p, input int glitch_at, input string tag);
    int per;
    int n;
    int full;
    per  = build_model(mm, p);
    full = (1 << mm) - 1;
    bus.m = mm[2:0];
    bus.prim_poly = p;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " ready_drop"}, 32'(bus.ready), 32'd0);
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      n++;
      if (n == glitch_at) begin
        bus.start = 1'b1;
        bus.m = 3'd3;
        bus.prim_poly = 5'b01011;
      end
      @(negedge clk);
      bus.start = 1'b0;
      bus.m = mm[2:0];
      bus.prim_poly = p;
    end
    check({tag, " busy_cycles"}, 32'(n), 32'(per));
    check({tag, " ready"}, 32'(bus.ready), 32'(per == full));
    check({tag, " err"}, 32'(bus.err), 32'(per != full));
    mdl_ready = (per == full);
    mdl_m4    = (mm == 4);
  endtask

  task automatic lk(input logic [3:0] e, input logic [3:0] v,
                    input logic [3:0] want_vec, input logic [3:0] want_exp, input string tag);
    logic [7:0] pair;
    bus.lk_exp_in = e;
    bus.lk_vec_in = v;
    exp_q.push_back({want_vec, want_exp});
    @(negedge clk);
    pair = exp_q.pop_front();
    check({tag, " lk_vec_out"}, 32'(bus.lk_vec_out), 32'(pair[7:4]));
    check({tag, " lk_exp_out"}, 32'(bus.lk_exp_out), 32'(pair[3:0]));
  endtask

  task automatic lk_model(input int count, input string tag);
    logic [3:0] e, v, we, wv;
    for (int i = 0; i < count; i++) begin
      e  = 4'($urandom_range(0, 15));
      v  = 4'($urandom_range(0, 15));
      we = (mdl_ready && (mdl_m4 || !e[3])) ? mdl_exp[e] : 4'd0;
      wv = (mdl_ready && (mdl_m4 || !v[3])) ? mdl_log[v] : 4'd0;
      lk(e, v, we, wv, tag);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.m = 3'd0;
    bus.prim_poly = 5'd0;
    bus.lk_exp_in = 4'd0;
    bus.lk_vec_in = 4'd0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst ready", 32'(bus.ready), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    check("rst lk_vec_out", 32'(bus.lk_vec_out), 32'd0);
    check("rst lk_exp_out", 32'(bus.lk_exp_out), 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_build(4, 5'b10011, 0, "t1");
    lk(4'd5, 4'b1100, 4'b1100, 4'd5, "t1 a");
    lk(4'd8, 4'b0000, 4'b1101, 4'd0, "t1 b");
    lk_model(10, "t1 rnd");

    run_build(3, 5'b01011, 0, "t2");
    lk(4'd4, 4'b0101, 4'b0110, 4'd7, "t2 a");
    lk(4'd7, 4'b1000, 4'b0101, 4'd0, "t2 b");
    lk(4'd9, 4'b0000, 4'b0000, 4'd0, "t2 c");
    lk_model(10, "t2 rnd");

    run_build(3, 5'b01101, 0, "t3a");
    lk(4'd5, 4'b0011, 4'b0111, 4'd7, "t3a");
    run_build(4, 5'b11001, 0, "t3b");
    lk(4'd6, 4'b1110, 4'b1101, 4'd8, "t3b");
    lk_model(10, "t3b rnd");

    run_build(4, 5'b11111, 0, "t4");
    lk(4'd1, 4'b1000, 4'd0, 4'd0, "t4");
    lk_model(4, "t4 rnd");

    run_build(5, 5'b10011, 0, "t5 m5");
    run_build(4, 5'b01011, 0, "t5 p4zero");
    run_build(3, 5'b11011, 0, "t5 highbit");
    lk(4'd2, 4'b0100, 4'd0, 4'd0, "t5");

    // Reset on the 4th build edge.
    bus.m = 3'd4;
    bus.prim_poly = 5'b10011;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6 rst busy", 32'(bus.busy), 32'd0);
    check("t6 rst ready", 32'(bus.ready), 32'd0);
    check("t6 rst err", 32'(bus.err), 32'd0);
    check("t6 rst lk_vec_out", 32'(bus.lk_vec_out), 32'd0);
    check("t6 rst lk_exp_out", 32'(bus.lk_exp_out), 32'd0);
    check("t6 rst state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;
    mdl_ready = 1'b0;
    @(negedge clk);

    run_build(4, 5'b10011, 3, "t6 glitch");
    lk(4'd5, 4'b1100, 4'b1100, 4'd5, "t6");
    lk_model(6, "t6 rnd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf_table_builder.md
Name: gf_table_builder

Overview:
Sequential log/antilog table generator for GF(2^m), m = 3 or 4, upstream of the GF adder.
- On start, steps an LFSR defined by prim_poly and fills two 16-entry tables: exponent code -> element vector, and element vector -> exponent code.
- Rejects primitive polynomials that are illegal or non-primitive.
- Once READY, serves both lookups with one-cycle registered latency.
- Adder-compatible encoding:
  - Exponent code 0 = zero element; code k (1..2^m-1) = alpha^(k-1).
  - Element vector bit[m-1-i] = coefficient of x^i, so bit[m-1] = x^0.

Parameters:
None. Field size is selected at run time by m; tables are sized for m_max = 4 (16 entries x 4 bits each).

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
start  input  1  one-cycle pulse: capture m/prim_poly and begin build
m  input  3  field degree; only 3 and 4 are legal
prim_poly  input  5  polynomial, standard order, bit i = x^i (e.g. 01011 = x^3+x+1)
busy  output  1  build in progress
ready  output  1  tables valid for the captured m/prim_poly
err  output  1  illegal m/poly, or poly not primitive
lk_exp_in  input  4  exponent code to convert
lk_vec_out  output  4  element vector for lk_exp_in, registered
lk_vec_in  input  4  element vector to convert
lk_exp_out  output  4  exponent code for lk_vec_in, registered

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE; busy=ready=err=0; lk_vec_out=lk_exp_out=0. Table contents are don't-care.
- States: IDLE, BUILD, READY, ERR.

IDLE / READY / ERR, on start=1:
- Capture M=m and P=prim_poly.
- Legal means all of the following:
  - M is 3 or 4.
  - P[M]=1 and P[0]=1.
  - Bits of P above M are 0.
- Legal: go to BUILD with LFSR s=1 (standard order, M bits) and step counter k=1. Clear ready and err. Write exp_tab[0]=0 and log_tab[0]=0.
- Illegal: go to ERR with err=1, ready=0.

BUILD, one write per cycle:
- rev(s) is s bit-reversed into the element encoding.
- Write exp_tab[k]=rev(s) and log_tab[rev(s)]=k.
- Next s = (s<<1 masked to M bits) XOR (s[M-1] ? P[M-1:0] : 0).
- k increments each cycle. busy=1 throughout BUILD.
- Early return: if next s == 1 while k < 2^M-1, the poly is non-primitive. Go to ERR with err=1, busy=0, on that edge.
- Completion: after the write with k = 2^M-1, go to READY (busy=0, ready=1). Next s must equal 1 here; otherwise go to ERR.
- Timing: start sampled at edge T gives busy=1 over edges T+1..T+2^M-1 and ready=1 from edge T+2^M. That is 7 busy cycles for M=3 and 15 for M=4.
- start during BUILD is ignored.
- rst_n=0 mid-BUILD: return to IDLE, all outputs 0 on that edge.

Lookups (every edge):
- lk_vec_out <= exp_tab[lk_exp_in]; lk_exp_out <= log_tab[lk_vec_in]. Both registered, latency 1.
- The output is 0 when any of these holds:
  - ready=0.
  - lk_exp_in >= 2^M.
  - M=3 and lk_vec_in[3]=1.
- Unwritten log entries cannot occur for a primitive P, since every nonzero vector is written exactly once.

ERR:
- err stays 1, ready=0, lookups return 0, until a legal start or reset.

Test Plan:
1. Reset, m=4, P=10011, start at edge 0 -> busy=1 on edges 1..15; ready=1 at edge 16. Then lk_exp_in=5 -> lk_vec_out=1100; lk_exp_in=8 -> 1101; lk_vec_in=1100 -> lk_exp_out=5; lk_vec_in=0000 -> 0000. Each result appears one cycle after the input.
2. m=3, P=01011 -> ready after 7 busy cycles. exp 4 -> 0110; exp 7 -> 0101; vec 0101 -> exp 7; vec 1000 -> 0 (bit3 invalid for m=3); exp 9 -> 0.
3. m=3, P=01101 -> exp 5 -> 0111; vec 0011 -> exp 7. Then a restart with m=4, P=11001 -> ready drops on the next edge; after rebuild, exp 6 -> 1101 and vec 1110 -> exp 8.
4. m=4, P=11111 (period 5) -> busy for 5 cycles, then err=1, ready=0, and all lookups return 0.
5. Illegal inputs: m=5; or m=4, P=01011 (P[4]=0); or m=3, P=11011 (bit above M set) -> err=1 on the next edge, busy never asserts.
6. rst_n=0 at the 4th BUILD cycle -> all outputs 0 at that edge, state IDLE. start pulsed during BUILD -> ignored; completion timing unchanged.
